trap_ctrl: RTL
==============

// Module: trap_ctrl
// PURPOSE
// - Collects exception reports from EXC_PORTS writeback/decode sources and keeps the single oldest pending one, ordered by robIdx.
// - When that instruction reaches the ROB head, runs the trap sequence: pipeline flush, CSR trap write (trapInfo_t), then PC redirect to mtvec.
// - Sits between the backend writeback ports/ROB and the CSR file/fetch redirect.
// PARAMETERS
// - EXC_PORTS  4  number of exception report ports (>=1)
// PORTS
// - clk             in   1                  core clock
// - rst             in   1                  asynchronous, active-high reset
// - i_exc_vld       in   EXC_PORTS          per-port exception report valid
// - i_exc_robIdx    in   EXC_PORTS x robIdx_t  robIdx of faulting instruction
// - i_exc_cause     in   EXC_PORTS x 16     rv_trap_t::exception code
// - i_exc_tval      in   EXC_PORTS x XLEN   tval (inst bits / mem address)
// - i_rob_head      in   robIdx_t           current ROB head index
// - i_head_vld      in   1                  ROB head entry valid
// - i_head_pc       in   XLEN               pc of ROB head entry (becomes epc)
// - i_squash_vld    in   1                  branch squash of all entries younger than i_squash_robIdx
// - i_squash_robIdx in   robIdx_t           squash point (itself survives)
// - i_mtvec         in   XLEN               mtvec CSR value (mode in [1:0])
// - o_busy          out  1                  sequence in progress; commit must stall
// - o_flush         out  1                  one-cycle global flush pulse
// - o_csr_vld       out  1                  trap CSR write request
// - o_csr_info      out  trapInfo_t        cause/epc/tval for the CSR write
// - o_csr_intr      out  1                  1 = interrupt trap
// - i_csr_rdy       in   1                  CSR accepts write
// - o_redir_vld     out  1                  fetch redirect request
// - o_redir_pc      out  XLEN              redirect target
// - i_redir_rdy     in   1                  fetch accepts redirect
// BEHAVIOUR
// - Reset: state IDLE, pending cleared; all outputs 0.
// - Age = (robIdx - i_rob_head) mod ROB_SIZE at robIdx_t width; smaller age = older.
// - Same-cycle reports: oldest wins, ties -> lowest port index. Replaces held entry only if strictly older.
// - States: IDLE (none held) -> HOLD on any report; HOLD -> FLUSH when i_head_vld && i_rob_head==held robIdx.
// - FLUSH: o_flush=1 exactly one cycle -> CSRWR. o_busy=1 in FLUSH/CSRWR/REDIR.
// - CSRWR: o_csr_vld=1, o_csr_info held stable until i_csr_rdy; accept -> REDIR.
// - REDIR: o_redir_vld=1; pc = mtvec[XLEN-1:2]<<2, or +4*cause if mode==1 and interrupt. Accept -> IDLE.
// - epc latched from i_head_pc on HOLD->FLUSH; cause/tval latched at capture.
// - Reports arriving in FLUSH/CSRWR/REDIR are dropped (belong to flushed instructions).
// - Squash in HOLD: if held age > squash age, clear held -> IDLE; same-cycle new reports younger than the squash point are also dropped; squash and head-match in one cycle: squash evaluated first.
// - Report and head-match in the same cycle on an older robIdx: capture the new one, stay in HOLD.
// - Reset mid-sequence: immediate return to IDLE, any in-flight request deasserted.
// CONFIGURATION
// - TRAP_INTR_EN defined: adds ports i_intr_vld(1), i_intr_cause(16). In IDLE with i_head_vld and i_intr_vld, the interrupt is
//   taken at the head (epc=i_head_pc, tval=0, o_csr_intr=1) -> FLUSH. A held exception wins over a same-cycle interrupt.
// - Undefined: no interrupt ports, o_csr_intr tied 0, vectored offset never applied.
// STRUCTURE
// - Shared package trap_ctrl_pkg: state enum (IDLE/HOLD/FLUSH/CSRWR/REDIR), robAge function, pending-entry struct (robIdx, cause, tval).
// - Sub-module trap_age_select: combinational oldest-of-EXC_PORTS selector tree (vld, robIdx, cause, tval out).
// TESTING
// - Head=0; port2 reports robIdx 5 cause 5 tval 0x80; head advances to 5 -> flush pulse, CSR {5, pc5, 0x80}, redirect mtvec&~3.
// - Same cycle: port0 robIdx 9, port3 robIdx 3 (head 0) -> robIdx 3 kept; later report robIdx 1 replaces; robIdx 7 ignored.
// - Wrap: ROB_SIZE 64, head 60, reports robIdx 2 and 62 -> 62 selected (age 2 vs 6).
// - Held robIdx 10, squash at robIdx 8 -> pending cleared, no flush; squash at 12 -> pending kept.
// - i_csr_rdy low 3 cycles, i_redir_rdy low 2 -> outputs stable, o_busy held, reports dropped, single flush only.
// - TRAP_INTR_EN: mtvec mode 1 base 0x1000, intr cause 7 -> redirect 0x101C, o_csr_intr=1; rst asserted in CSRWR -> all outputs 0 next edge.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap controller: FSM states, trap CSR payload, held exception entry, ROB age helper.
package trap_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int ROB_SIZE = 64;
    localparam int ROB_W    = $clog2(ROB_SIZE);
    localparam int CAUSE_W  = 16;

    typedef logic [ROB_W-1:0] robIdx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        FLUSH = 3'd2,
        CSRWR = 3'd3,
        REDIR = 3'd4
    } trap_state_e;

    typedef struct packed {
        logic [CAUSE_W-1:0] cause;
        logic [XLEN-1:0]    epc;
        logic [XLEN-1:0]    tval;
    } trapInfo_t;

    typedef struct packed {
        robIdx_t            robIdx;
        logic [CAUSE_W-1:0] cause;
        logic [XLEN-1:0]    tval;
    } pend_t;

    // ROB_SIZE is a power of two, so wrapping subtraction is the modular distance from head.
    function automatic robIdx_t robAge(input robIdx_t idx, input robIdx_t head);
        return idx - head;
    endfunction

endpackage

// File: rtl/trap_age_select.sv
// Combinational oldest-of-N exception selector; ties resolve to the lowest port index.
module trap_age_select
    import trap_ctrl_pkg::*;
#(
    parameter int EXC_PORTS = 4
) (
    input  logic [EXC_PORTS-1:0]              vld_i,
    input  robIdx_t [EXC_PORTS-1:0]           rob_idx_i,
    input  logic [EXC_PORTS-1:0][CAUSE_W-1:0] cause_i,
    input  logic [EXC_PORTS-1:0][XLEN-1:0]    tval_i,
    input  robIdx_t                           head_i,
    output logic                              vld_o,
    output robIdx_t                           rob_idx_o,
    output logic [CAUSE_W-1:0]                cause_o,
    output logic [XLEN-1:0]                   tval_o,
    output robIdx_t                           age_o
);

    // Priority scan: a later port only wins when strictly older.
    always_comb begin
        vld_o     = 1'b0;
        rob_idx_o = '0;
        cause_o   = '0;
        tval_o    = '0;
        age_o     = '0;
        for (int p = 0; p < EXC_PORTS; p++) begin
            if (vld_i[p] && (!vld_o || (robAge(rob_idx_i[p], head_i) < age_o))) begin
                vld_o     = 1'b1;
                rob_idx_o = rob_idx_i[p];
                cause_o   = cause_i[p];
                tval_o    = tval_i[p];
                age_o     = robAge(rob_idx_i[p], head_i);
            end else begin
                vld_o     = vld_o;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: holds the oldest pending exception and runs flush -> CSR write -> redirect at ROB head.
// Optional macro TRAP_INTR_EN adds interrupt inputs and vectored mtvec redirection.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int EXC_PORTS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [EXC_PORTS-1:0]              i_exc_vld,
    input  robIdx_t [EXC_PORTS-1:0]           i_exc_robIdx,
    input  logic [EXC_PORTS-1:0][CAUSE_W-1:0] i_exc_cause,
    input  logic [EXC_PORTS-1:0][XLEN-1:0]    i_exc_tval,
    input  robIdx_t                           i_rob_head,
    input  logic                              i_head_vld,
    input  logic [XLEN-1:0]                   i_head_pc,
    input  logic                              i_squash_vld,
    input  robIdx_t                           i_squash_robIdx,
`ifdef TRAP_INTR_EN
    input  logic                              i_intr_vld,
    input  logic [CAUSE_W-1:0]                i_intr_cause,
`endif
    input  logic [XLEN-1:0]                   i_mtvec,
    output logic                              o_busy,
    output logic                              o_flush,
    output logic                              o_csr_vld,
    output trapInfo_t                         o_csr_info,
    output logic                              o_csr_intr,
    input  logic                              i_csr_rdy,
    output logic                              o_redir_vld,
    output logic [XLEN-1:0]                   o_redir_pc,
    input  logic                              i_redir_rdy
);

    trap_state_e          state_q, state_d;
    pend_t                pend_q, pend_d;
    logic [XLEN-1:0]      epc_q, epc_d;
`ifdef TRAP_INTR_EN
    logic                 intr_q, intr_d;
`endif

    robIdx_t              sq_age;
    robIdx_t              held_age;
    logic                 held_keep;
    logic [EXC_PORTS-1:0] rep_vld;
    logic                 sel_vld;
    robIdx_t              sel_idx;
    logic [CAUSE_W-1:0]   sel_cause;
    logic [XLEN-1:0]      sel_tval;
    robIdx_t              sel_age;
    logic [XLEN-1:0]      redir_pc;

    // Reports on instructions younger than a same-cycle squash point never compete.
    always_comb begin
        sq_age  = robAge(i_squash_robIdx, i_rob_head);
        rep_vld = '0;
        for (int p = 0; p < EXC_PORTS; p++) begin
            rep_vld[p] = i_exc_vld[p] &&
                         !(i_squash_vld && (robAge(i_exc_robIdx[p], i_rob_head) > sq_age));
        end
    end

    trap_age_select #(
        .EXC_PORTS (EXC_PORTS)
    ) u_sel (
        .vld_i     (rep_vld),
        .rob_idx_i (i_exc_robIdx),
        .cause_i   (i_exc_cause),
        .tval_i    (i_exc_tval),
        .head_i    (i_rob_head),
        .vld_o     (sel_vld),
        .rob_idx_o (sel_idx),
        .cause_o   (sel_cause),
        .tval_o    (sel_tval),
        .age_o     (sel_age)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Held exception payload and latched epc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            epc_q  <= '0;
`ifdef TRAP_INTR_EN
            intr_q <= 1'b0;
`endif
        end else begin
            pend_q <= pend_d;
            epc_q  <= epc_d;
`ifdef TRAP_INTR_EN
            intr_q <= intr_d;
`endif
        end
    end

    // Next-state logic; in HOLD a squash is resolved before replacement or head match.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        epc_d     = epc_q;
`ifdef TRAP_INTR_EN
        intr_d    = intr_q;
`endif
        held_age  = robAge(pend_q.robIdx, i_rob_head);
        held_keep = !(i_squash_vld && (held_age > sq_age));
        case (state_q)
            IDLE: begin
`ifdef TRAP_INTR_EN
                if (i_head_vld && i_intr_vld) begin
                    state_d       = FLUSH;
                    pend_d.robIdx = i_rob_head;
                    pend_d.cause  = i_intr_cause;
                    pend_d.tval   = '0;
                    epc_d         = i_head_pc;
                    intr_d        = 1'b1;
                end else if (sel_vld) begin
                    state_d = HOLD;
                    pend_d  = '{robIdx: sel_idx, cause: sel_cause, tval: sel_tval};
                    intr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
`else
                if (sel_vld) begin
                    state_d = HOLD;
                    pend_d  = '{robIdx: sel_idx, cause: sel_cause, tval: sel_tval};
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            HOLD: begin
                if (!held_keep) begin
                    if (sel_vld) begin
                        state_d = HOLD;
                        pend_d  = '{robIdx: sel_idx, cause: sel_cause, tval: sel_tval};
                    end else begin
                        state_d = IDLE;
                    end
                end else if (sel_vld && (sel_age < held_age)) begin
                    state_d = HOLD;
                    pend_d  = '{robIdx: sel_idx, cause: sel_cause, tval: sel_tval};
                end else if (i_head_vld && (i_rob_head == pend_q.robIdx)) begin
                    state_d = FLUSH;
                    epc_d   = i_head_pc;
                end else begin
                    state_d = HOLD;
                end
            end
            FLUSH: begin
                state_d = CSRWR;
            end
            CSRWR: begin
                if (i_csr_rdy) begin
                    state_d = REDIR;
                end else begin
                    state_d = CSRWR;
                end
            end
            REDIR: begin
                if (i_redir_rdy) begin
                    state_d = IDLE;
                end else begin
                    state_d = REDIR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Redirect target: mtvec base, plus 4*cause for vectored interrupts.
    always_comb begin
        redir_pc = {i_mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_INTR_EN
        if (intr_q && (i_mtvec[1:0] == 2'b01)) begin
            redir_pc = {i_mtvec[XLEN-1:2], 2'b00} +
                       ({{(XLEN-CAUSE_W){1'b0}}, pend_q.cause} << 2);
        end else begin
            redir_pc = {i_mtvec[XLEN-1:2], 2'b00};
        end
`endif
    end

    // Output decode from the registered state and payload.
    always_comb begin
        o_busy      = 1'b0;
        o_flush     = 1'b0;
        o_csr_vld   = 1'b0;
        o_csr_info  = '0;
        o_csr_intr  = 1'b0;
        o_redir_vld = 1'b0;
        o_redir_pc  = '0;
        case (state_q)
            FLUSH: begin
                o_busy  = 1'b1;
                o_flush = 1'b1;
            end
            CSRWR: begin
                o_busy     = 1'b1;
                o_csr_vld  = 1'b1;
                o_csr_info = '{cause: pend_q.cause, epc: epc_q, tval: pend_q.tval};
`ifdef TRAP_INTR_EN
                o_csr_intr = intr_q;
`endif
            end
            REDIR: begin
                o_busy      = 1'b1;
                o_redir_vld = 1'b1;
                o_redir_pc  = redir_pc;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule
